ascon_bdi_sender: RTL and testbench
===================================

ASCON_BDI_SENDER -- requirements
Module: ascon_bdi_sender

Interface
REQ-001 clk_i  in  1  single clock; all logic on rising edge.
REQ-002 rst_n_i  in  1  reset, synchronous, active-low.
REQ-003 start_i  in  1  one-cycle request to send one message; sampled only in IDLE.
REQ-004 mode_i  in  3 / dec_i in 1 / hash_i in 1  operation select, latched at start.
REQ-005 ad_len_i  in  7 / text_len_i in 7  AD and text lengths in bytes (0..127), latched at start.
REQ-006 out_size_i  in  8  hash output size, latched at start.
REQ-007 key_in_i in 128 / nonce_in_i in 128  key and nonce, latched at start; word 0 = bits [127:96].
REQ-008 src_data_i in 32 / src_valid_i in 1 / src_ready_o out 1  host stream carrying AD, then text, then tag words.
REQ-009 core_ready_i  in  1 / done_i in 1  core idle flag and end-of-operation pulse.
REQ-010 key_o out 32 / key_valid_o out 1 / key_last_o out 1 / key_ready_i in 1  key channel to core.
REQ-011 bd_o out 32 / bd_valid_o out 1 / bd_type_o out 3 / bd_last_o out 1 / bd_vld_byte_o out 4 / eoi_o out 1 / bdi_ready_i in 1  data channel to core.
REQ-012 bdo_valid_i in 1 / bdo_ready_o out 1 / rx_cnt_o out 8 / busy_o out 1  result sink and status.

Function
REQ-013 bd_type encoding SHALL be: 000 config, 001 nonce, 010 AD, 011 text, 100 tag.
REQ-014 FSM states SHALL be IDLE, KEY, CFG, NONCE, AD, TEXT, TAG, WAIT.
REQ-015 IDLE->KEY (or CFG if hash) SHALL occur on start_i && core_ready_i; start_i outside IDLE or with core_ready_i=0 is ignored.
REQ-016 KEY SHALL send 4 words MSW first, key_last_o on word 3; hash mode skips KEY.
REQ-017 CFG SHALL send one word {8'h00, {1'b0,ad_len}, out_size, 3'b000, mode, dec, hash}, bd_last_o=1, vld_byte=1111.
REQ-018 NONCE SHALL send 4 words from nonce_in, bd_last_o on word 3; skipped when hash.
REQ-019 AD/TEXT SHALL forward ceil(len/4) host words each; a zero-length segment is skipped entirely.
REQ-020 Last word of a segment SHALL carry bd_last_o=1 and vld_byte = 1111, 1000, 1100, 1110 for len%4 = 0,1,2,3; other words 1111.
REQ-021 TAG SHALL forward 4 host words only when dec=1 && hash=0, bd_last_o on word 3.
REQ-022 eoi_o SHALL be 1 exactly on the final bd word of the message, valid with that word.
REQ-023 Transfer occurs when valid && ready; valid, data and sideband SHALL hold stable until transfer; valid never depends combinationally on ready.
REQ-024 Outputs SHALL be registered; src_ready_o = (state in AD/TEXT/TAG) && (!bd_valid_o || bdi_ready_i), giving full throughput of one word per cycle.
REQ-025 After the final word transfers, FSM SHALL enter WAIT; WAIT->IDLE on done_i.
REQ-026 done_i arriving in the same cycle as the final word transfer SHALL be honoured (direct return to IDLE).
REQ-027 bdo_ready_o SHALL be 1 whenever busy_o=1; rx_cnt_o clears at start, increments on bdo_valid_i && bdo_ready_o, saturates at 255.
REQ-028 busy_o SHALL be 1 in every state except IDLE.
REQ-029 Word counters SHALL be 5 bits (max 32 words per segment), compared against ceil(len/4) computed as (len+3)>>2.

Reset
REQ-030 On rst_n_i=0 at a clock edge: state IDLE; all valid/last/eoi outputs 0; key_o, bd_o, bd_type_o, bd_vld_byte_o 0; rx_cnt_o 0; busy_o 0; src_ready_o 0; bdo_ready_o 0.
REQ-031 Reset mid-message SHALL abort immediately with no further beats; next start begins a fresh message.

Verification
REQ-032 Encrypt, ad_len=5, text_len=8, ready always 1 -> 4 key beats, cfg 0x0005_xx_0?, 4 nonce, AD 2 beats (last vld 1000), text 2 beats (last 1111, eoi=1), no tag.
REQ-033 Decrypt, ad_len=0, text_len=3 -> AD skipped, text 1 beat vld 1110 last=1 eoi=0, tag 4 beats, eoi on tag word 3.
REQ-034 Hash, ad_len=16, out_size=32 -> no key/nonce/tag; cfg then 4 AD beats, eoi on 4th; cfg bit0=1.
REQ-035 bdi_ready_i toggled randomly and src_valid_i gapped -> no lost/duplicated words, outputs stable while stalled.
REQ-036 start_i while busy, and rst_n_i=0 during TEXT -> start ignored; reset returns all outputs to REQ-030 values next cycle.
REQ-037 done_i coincident with final beat, 3 bdo_valid_i pulses -> IDLE next cycle, rx_cnt_o=3.

Source files
------------

// File: rtl/ascon_bdi_sender.sv
// Sequences one Ascon message (key, config, nonce, AD, text, tag) from latched
// parameters and a host word stream onto the core's key and bd channels.
module ascon_bdi_sender (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         start_i,
  input  logic [2:0]   mode_i,
  input  logic         dec_i,
  input  logic         hash_i,
  input  logic [6:0]   ad_len_i,
  input  logic [6:0]   text_len_i,
  input  logic [7:0]   out_size_i,
  input  logic [127:0] key_in_i,
  input  logic [127:0] nonce_in_i,
  input  logic [31:0]  src_data_i,
  input  logic         src_valid_i,
  output logic         src_ready_o,
  input  logic         core_ready_i,
  input  logic         done_i,
  output logic [31:0]  key_o,
  output logic         key_valid_o,
  output logic         key_last_o,
  input  logic         key_ready_i,
  output logic [31:0]  bd_o,
  output logic         bd_valid_o,
  output logic [2:0]   bd_type_o,
  output logic         bd_last_o,
  output logic [3:0]   bd_vld_byte_o,
  output logic         eoi_o,
  input  logic         bdi_ready_i,
  input  logic         bdo_valid_i,
  output logic         bdo_ready_o,
  output logic [7:0]   rx_cnt_o,
  output logic         busy_o
);

  typedef enum logic [2:0] {IDLE, KEY, CFG, NONCE, AD, TEXT, TAG, WAIT} state_t;

  state_t       state, state_n, nxt;
  logic [4:0]   cnt, cnt_n;
  logic         fin, fin_n;
  logic [2:0]   mode_q;
  logic         dec_q, hash_q;
  logic [6:0]   ad_len_q, text_len_q;
  logic [7:0]   out_size_q;
  logic [127:0] key_q, nonce_q;
  logic [5:0]   seg_words;
  logic         last_word, bd_free, bd_fire, key_free, key_fire, bd_gen, src_take;
  logic         key_load, bd_load, start_ok;
  logic [31:0]  bd_word;
  logic [2:0]   bd_type_n;
  logic [3:0]   vld_n;

  function automatic logic [3:0] tail_mask(input logic [1:0] rem);
    case (rem)
      2'd0:    tail_mask = 4'b1111;
      2'd1:    tail_mask = 4'b1000;
      2'd2:    tail_mask = 4'b1100;
      default: tail_mask = 4'b1110;
    endcase
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    sat_inc = (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [31:0] word_of(input logic [127:0] v, input logic [1:0] idx);
    case (idx)
      2'd0:    word_of = v[127:96];
      2'd1:    word_of = v[95:64];
      2'd2:    word_of = v[63:32];
      default: word_of = v[31:0];
    endcase
  endfunction

  // Segment that follows s, skipping empty or mode-disabled ones; WAIT means s was the last.
  function automatic state_t after_seg(input state_t s, input logic h, input logic d,
                                       input logic [6:0] al, input logic [6:0] tl);
    after_seg = WAIT;
    if (s == KEY)
      after_seg = CFG;
    else if (s == CFG && !h)
      after_seg = NONCE;
    else if ((s == CFG || s == NONCE) && al != 7'd0)
      after_seg = AD;
    else if ((s == CFG || s == NONCE || s == AD) && tl != 7'd0)
      after_seg = TEXT;
    else if (s != TAG && d && !h)
      after_seg = TAG;
  endfunction

  assign busy_o      = (state != IDLE);
  assign bdo_ready_o = busy_o;
  assign bd_free     = !bd_valid_o || bdi_ready_i;
  assign bd_fire     = bd_valid_o && bdi_ready_i;
  assign key_free    = !key_valid_o || key_ready_i;
  assign key_fire    = key_valid_o && key_ready_i;
  assign bd_gen      = (state == CFG) || (state == NONCE);
  assign src_ready_o = (state == AD || state == TEXT || state == TAG) && !fin && bd_free;
  assign src_take    = src_ready_o && src_valid_i;
  assign nxt         = after_seg(state, hash_q, dec_q, ad_len_q, text_len_q);

  always_comb begin
    case (state)
      CFG:     seg_words = 6'd1;
      AD:      seg_words = 6'(({1'b0, ad_len_q} + 8'd3) >> 2);
      TEXT:    seg_words = 6'(({1'b0, text_len_q} + 8'd3) >> 2);
      default: seg_words = 6'd4;
    endcase
  end

  assign last_word = ({1'b0, cnt} == seg_words - 6'd1);

  always_comb begin
    bd_type_n = 3'b000;
    bd_word   = src_data_i;
    vld_n     = 4'b1111;
    case (state)
      CFG:   bd_word = {8'h00, 1'b0, ad_len_q, out_size_q, 3'b000, mode_q, dec_q, hash_q};
      NONCE: begin bd_type_n = 3'b001; bd_word = word_of(nonce_q, cnt[1:0]); end
      AD:    begin bd_type_n = 3'b010; if (last_word) vld_n = tail_mask(ad_len_q[1:0]); end
      TEXT:  begin bd_type_n = 3'b011; if (last_word) vld_n = tail_mask(text_len_q[1:0]); end
      TAG:   bd_type_n = 3'b100;
      default: ;
    endcase
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    fin_n    = fin;
    key_load = 1'b0;
    bd_load  = 1'b0;
    start_ok = 1'b0;
    case (state)
      IDLE: if (start_i && core_ready_i) begin
        start_ok = 1'b1;
        state_n  = hash_i ? CFG : KEY;
        cnt_n    = '0;
        fin_n    = 1'b0;
      end
      KEY: if (key_free) begin
        key_load = 1'b1;
        cnt_n    = cnt + 5'd1;
        if (last_word) begin
          cnt_n   = '0;
          state_n = CFG;
        end
      end
      CFG, NONCE, AD, TEXT, TAG: begin
        // fin: the message's final word is issued and waiting for the core to take it
        if (fin) begin
          if (bd_fire) begin
            fin_n   = 1'b0;
            state_n = done_i ? IDLE : WAIT;
          end
        end else if (bd_gen ? bd_free : src_take) begin
          bd_load = 1'b1;
          cnt_n   = cnt + 5'd1;
          if (last_word) begin
            cnt_n = '0;
            if (nxt == WAIT) fin_n = 1'b1;
            else             state_n = nxt;
          end
        end
      end
      WAIT: if (done_i) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
      cnt   <= '0;
      fin   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      fin   <= fin_n;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      mode_q <= '0; dec_q <= 1'b0; hash_q <= 1'b0;
      ad_len_q <= '0; text_len_q <= '0; out_size_q <= '0;
      key_q <= '0; nonce_q <= '0;
      rx_cnt_o <= '0;
      key_o <= '0; key_valid_o <= 1'b0; key_last_o <= 1'b0;
      bd_o <= '0; bd_valid_o <= 1'b0; bd_type_o <= '0;
      bd_last_o <= 1'b0; bd_vld_byte_o <= '0; eoi_o <= 1'b0;
    end else begin
      if (start_ok) begin
        mode_q     <= mode_i;
        dec_q      <= dec_i;
        hash_q     <= hash_i;
        ad_len_q   <= ad_len_i;
        text_len_q <= text_len_i;
        out_size_q <= out_size_i;
        key_q      <= key_in_i;
        nonce_q    <= nonce_in_i;
        rx_cnt_o   <= '0;
      end else if (bdo_valid_i && bdo_ready_o) begin
        rx_cnt_o <= sat_inc(rx_cnt_o);
      end
      if (key_load) begin
        key_o       <= word_of(key_q, cnt[1:0]);
        key_valid_o <= 1'b1;
        key_last_o  <= last_word;
      end else if (key_fire) begin
        key_valid_o <= 1'b0;
      end
      if (bd_load) begin
        bd_o          <= bd_word;
        bd_valid_o    <= 1'b1;
        bd_type_o     <= bd_type_n;
        bd_last_o     <= last_word;
        bd_vld_byte_o <= vld_n;
        eoi_o         <= last_word && (nxt == WAIT);
      end else if (bd_fire) begin
        bd_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ascon_bdi_sender.sv
// Randomised bench for ascon_bdi_sender: a queue-based message model predicts every
// key and bd beat, and each cycle's handshakes are checked against it.
module tb_ascon_bdi_sender;

  logic         clk = 1'b0;
  logic         rst_n_i, start_i, dec_i, hash_i, src_valid_i, src_ready_o;
  logic [2:0]   mode_i;
  logic [6:0]   ad_len_i, text_len_i;
  logic [7:0]   out_size_i, rx_cnt_o;
  logic [127:0] key_in_i, nonce_in_i;
  logic [31:0]  src_data_i, key_o, bd_o;
  logic         core_ready_i, done_i, key_valid_o, key_last_o, key_ready_i;
  logic         bd_valid_o, bd_last_o, eoi_o, bdi_ready_i, bdo_valid_i, bdo_ready_o, busy_o;
  logic [2:0]   bd_type_o;
  logic [3:0]   bd_vld_byte_o;

  always #5 clk = ~clk;

  ascon_bdi_sender dut (
    .clk_i(clk), .rst_n_i(rst_n_i), .start_i(start_i), .mode_i(mode_i), .dec_i(dec_i),
    .hash_i(hash_i), .ad_len_i(ad_len_i), .text_len_i(text_len_i), .out_size_i(out_size_i),
    .key_in_i(key_in_i), .nonce_in_i(nonce_in_i), .src_data_i(src_data_i),
    .src_valid_i(src_valid_i), .src_ready_o(src_ready_o), .core_ready_i(core_ready_i),
    .done_i(done_i), .key_o(key_o), .key_valid_o(key_valid_o), .key_last_o(key_last_o),
    .key_ready_i(key_ready_i), .bd_o(bd_o), .bd_valid_o(bd_valid_o), .bd_type_o(bd_type_o),
    .bd_last_o(bd_last_o), .bd_vld_byte_o(bd_vld_byte_o), .eoi_o(eoi_o),
    .bdi_ready_i(bdi_ready_i), .bdo_valid_i(bdo_valid_i), .bdo_ready_o(bdo_ready_o),
    .rx_cnt_o(rx_cnt_o), .busy_o(busy_o)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [2:0]  t;
    logic        l;
    logic [3:0]  v;
    logic        e;
  } beat_t;

  beat_t        exp_bd[$];
  logic [32:0]  exp_key[$];
  logic [31:0]  src_q[$];
  int           src_pos, errors, checks;
  logic [2:0]   m_mode;
  logic         m_dec, m_hash;
  logic [6:0]   m_al, m_tl;
  logic [7:0]   m_os;
  logic         bd_stall, key_stall;
  logic [41:0]  bd_prev;
  logic [33:0]  key_prev;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  function automatic logic [3:0] mask_of(input int len);
    if (len % 4 == 0) return 4'hF;
    return 4'(4'hF << (4 - len % 4));
  endfunction

  task automatic add_seg(input int len, input logic [2:0] t);
    int nw;
    nw = (len + 3) / 4;
    for (int i = 0; i < nw; i++) begin
      logic [31:0] w;
      w = $urandom;
      src_q.push_back(w);
      exp_bd.push_back('{d: w, t: t, l: (i == nw - 1), v: (i == nw - 1) ? mask_of(len) : 4'hF, e: 1'b0});
    end
  endtask

  // Message model: the ordered list of beats the core must see.
  task automatic build(input logic [2:0] mode, input logic d, input logic h,
                       input logic [6:0] al, input logic [6:0] tl, input logic [7:0] os);
    beat_t b;
    m_mode = mode; m_dec = d; m_hash = h; m_al = al; m_tl = tl; m_os = os;
    key_in_i   = {$urandom, $urandom, $urandom, $urandom};
    nonce_in_i = {$urandom, $urandom, $urandom, $urandom};
    exp_bd.delete(); exp_key.delete(); src_q.delete();
    if (!h)
      for (int i = 0; i < 4; i++) exp_key.push_back({i == 3, key_in_i[127 - 32*i -: 32]});
    exp_bd.push_back('{d: {8'h00, 1'b0, al, os, 3'b000, mode, d, h}, t: 3'b000, l: 1'b1, v: 4'hF, e: 1'b0});
    if (!h)
      for (int i = 0; i < 4; i++)
        exp_bd.push_back('{d: nonce_in_i[127 - 32*i -: 32], t: 3'b001, l: (i == 3), v: 4'hF, e: 1'b0});
    add_seg(int'(al), 3'b010);
    add_seg(int'(tl), 3'b011);
    if (d && !h)
      for (int i = 0; i < 4; i++) begin
        logic [31:0] w;
        w = $urandom;
        src_q.push_back(w);
        exp_bd.push_back('{d: w, t: 3'b100, l: (i == 3), v: 4'hF, e: 1'b0});
      end
    b = exp_bd[exp_bd.size() - 1];
    b.e = 1'b1;
    exp_bd[exp_bd.size() - 1] = b;
  endtask

  task automatic monitor();
    beat_t b;
    if (!rst_n_i) begin
      bd_stall = 1'b0; key_stall = 1'b0;
      return;
    end
    if (bd_stall)
      chk("bd_hold", 64'({bd_valid_o, bd_o, bd_type_o, bd_last_o, bd_vld_byte_o, eoi_o}), 64'(bd_prev));
    if (key_stall)
      chk("key_hold", 64'({key_valid_o, key_last_o, key_o}), 64'(key_prev));
    if (bd_valid_o && bdi_ready_i) begin
      if (exp_bd.size() == 0) chk("bd_extra_beat", 64'(bd_valid_o), 64'(0));
      else begin
        b = exp_bd.pop_front();
        chk("bd_beat", 64'({bd_o, bd_type_o, bd_last_o, bd_vld_byte_o, eoi_o}), 64'(b));
      end
    end
    if (key_valid_o && key_ready_i) begin
      if (exp_key.size() == 0) chk("key_extra_beat", 64'(key_valid_o), 64'(0));
      else chk("key_beat", 64'({key_last_o, key_o}), 64'(exp_key.pop_front()));
    end
    if (src_valid_i && src_ready_o) src_pos++;
    bd_stall  = bd_valid_o && !bdi_ready_i;
    bd_prev   = {bd_valid_o, bd_o, bd_type_o, bd_last_o, bd_vld_byte_o, eoi_o};
    key_stall = key_valid_o && !key_ready_i;
    key_prev  = {key_valid_o, key_last_o, key_o};
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, "_data"}, 64'({key_o, bd_o}), 64'(0));
    chk({name, "_ctrl"}, 64'({key_valid_o, key_last_o, bd_valid_o, bd_type_o, bd_last_o, bd_vld_byte_o,
                              eoi_o, rx_cnt_o, busy_o, src_ready_o, bdo_ready_o}), 64'(0));
  endtask

  task automatic do_reset();
    rst_n_i = 1'b0; start_i = 1'b0; src_valid_i = 1'b0; done_i = 1'b0; bdo_valid_i = 1'b0;
    bdi_ready_i = 1'b0; key_ready_i = 1'b0;
    tick();
    rst_n_i = 1'b1;
    exp_bd.delete(); exp_key.delete(); src_q.delete();
  endtask

  task automatic drive_start();
    mode_i = m_mode; dec_i = m_dec; hash_i = m_hash; ad_len_i = m_al; text_len_i = m_tl;
    out_size_i = m_os; core_ready_i = 1'b1; start_i = 1'b1; src_valid_i = 1'b0;
    src_pos = 0;
    tick();
    start_i = 1'b0;
    chk("busy_after_start", 64'({busy_o, bdo_ready_o}), 64'(2'b11));
  endtask

  task automatic drive_cycle(input bit rnd);
    bdi_ready_i = rnd ? ($urandom % 3 != 0) : 1'b1;
    key_ready_i = rnd ? ($urandom % 3 != 0) : 1'b1;
    src_valid_i = (src_pos < src_q.size()) && (rnd ? ($urandom % 4 != 0) : 1'b1);
    src_data_i  = (src_pos < src_q.size()) ? src_q[src_pos] : 32'h0;
    mode_i = 3'($urandom); dec_i = 1'($urandom); hash_i = 1'($urandom);
    ad_len_i = 7'($urandom); text_len_i = 7'($urandom); out_size_i = 8'($urandom);
  endtask

  task automatic run_msg(input bit rnd, input bit coinc, input int nbdo, input bit poke);
    int guard, issued;
    guard = 0; issued = 0;
    drive_start();
    while ((exp_bd.size() != 0 || exp_key.size() != 0) && guard < 3000) begin
      drive_cycle(rnd);
      bdo_valid_i = (issued < nbdo) && (guard % 2 == 0);
      if (bdo_valid_i) issued++;
      start_i = poke && (guard == 5);
      done_i  = coinc && exp_bd.size() == 1 && exp_key.size() == 0 && bd_valid_o && bdi_ready_i;
      tick();
      guard++;
    end
    start_i = 1'b0; src_valid_i = 1'b0; done_i = 1'b0; bdo_valid_i = 1'b0;
    chk("beats_remaining", 64'(exp_bd.size() + exp_key.size()), 64'(0));
    if (exp_bd.size() + exp_key.size() != 0) begin
      do_reset();
      return;
    end
    chk("src_consumed", 64'(src_pos), 64'(src_q.size()));
    if (coinc) begin
      chk("idle_after_coincident_done", 64'(busy_o), 64'(0));
    end else begin
      chk("wait_state", 64'({busy_o, bd_valid_o}), 64'(2'b10));
      while (issued < nbdo) begin
        bdo_valid_i = 1'b1;
        issued++;
        tick();
      end
      bdo_valid_i = 1'b0;
      chk("still_waiting", 64'(busy_o), 64'(1));
      done_i = 1'b1;
      tick();
      done_i = 1'b0;
      chk("idle_after_done", 64'(busy_o), 64'(0));
    end
    chk("rx_cnt", 64'(rx_cnt_o), 64'(nbdo > 255 ? 255 : nbdo));
  endtask

  initial begin
    int guard;
    errors = 0; checks = 0; src_pos = 0;
    bd_stall = 1'b0; key_stall = 1'b0; bd_prev = '0; key_prev = '0;
    mode_i = '0; dec_i = 0; hash_i = 0; ad_len_i = '0; text_len_i = '0; out_size_i = '0;
    key_in_i = '0; nonce_in_i = '0; src_data_i = '0; core_ready_i = 1'b1;
    do_reset();
    do_reset();
    chk_reset_vals("reset");

    // start with the core not ready is ignored
    bdi_ready_i = 1'b1; core_ready_i = 1'b0; start_i = 1'b1;
    tick();
    start_i = 1'b0; core_ready_i = 1'b1;
    chk("start_ignored_core_busy", 64'(busy_o), 64'(0));

    // encrypt, AD 5, text 8, full-rate handshakes
    build(3'b001, 1'b0, 1'b0, 7'd5, 7'd8, 8'd0);
    chk("pin_enc_count", 64'(exp_bd.size()), 64'(9));
    chk("pin_enc_cfg", 64'(exp_bd[0].d), 64'(32'h0005_0004));
    chk("pin_enc_ad_last", 64'({exp_bd[6].l, exp_bd[6].v}), 64'(5'b1_1000));
    chk("pin_enc_final", 64'({exp_bd[8].l, exp_bd[8].v, exp_bd[8].e}), 64'(6'b1_1111_1));
    chk("pin_enc_key_last", 64'(exp_key[3][32]), 64'(1));
    run_msg(1'b0, 1'b0, 2, 1'b0);

    // decrypt, no AD, text 3, stalled handshakes
    build(3'b001, 1'b1, 1'b0, 7'd0, 7'd3, 8'd0);
    chk("pin_dec_text", 64'({exp_bd[5].t, exp_bd[5].l, exp_bd[5].v, exp_bd[5].e}), 64'(9'b011_1_1110_0));
    chk("pin_dec_tag_end", 64'({exp_bd[9].t, exp_bd[9].e}), 64'(4'b100_1));
    run_msg(1'b1, 1'b0, 5, 1'b1);

    // hash, AD 16, out 32
    build(3'b010, 1'b0, 1'b1, 7'd16, 7'd0, 8'd32);
    chk("pin_hash_cfg", 64'(exp_bd[0].d), 64'(32'h0010_2009));
    chk("pin_hash_shape", 64'({exp_key.size(), exp_bd.size()}), 64'({32'd0, 32'd5}));
    run_msg(1'b0, 1'b0, 0, 1'b0);

    // done coincident with the final beat, three result beats
    build(3'b001, 1'b0, 1'b0, 7'd5, 7'd8, 8'd0);
    run_msg(1'b0, 1'b1, 3, 1'b0);

    // segment-size extremes: 32-word segments, config-only and nonce-only endings
    build(3'b011, 1'b1, 1'b0, 7'd127, 7'd127, 8'd16);
    run_msg(1'b1, 1'b0, 4, 1'b1);
    build(3'b100, 1'b0, 1'b1, 7'd0, 7'd0, 8'd16);
    run_msg(1'b1, 1'b1, 1, 1'b0);
    build(3'b001, 1'b0, 1'b0, 7'd0, 7'd0, 8'd0);
    run_msg(1'b1, 1'b0, 0, 1'b0);

    // rx_cnt saturation
    build(3'b001, 1'b0, 1'b0, 7'd4, 7'd4, 8'd0);
    run_msg(1'b0, 1'b0, 300, 1'b0);

    for (int k = 0; k < 10; k++) begin
      build(3'($urandom), 1'($urandom), ($urandom % 4 == 0),
            (k % 3 == 0) ? 7'd0 : 7'($urandom), (k % 4 == 1) ? 7'd0 : 7'($urandom), 8'($urandom));
      run_msg(1'b1, 1'($urandom), int'($urandom % 7), 1'b1);
    end

    // reset while text is flowing aborts the message
    build(3'b001, 1'b0, 1'b0, 7'd8, 7'd40, 8'd0);
    drive_start();
    guard = 0;
    while (!(bd_valid_o && bd_type_o == 3'b011) && guard < 500) begin
      drive_cycle(1'b1);
      tick();
      guard++;
    end
    chk("reached_text", 64'(bd_type_o), 64'(3'b011));
    do_reset();
    chk_reset_vals("abort");
    bdi_ready_i = 1'b1; key_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("no_beats_after_abort", 64'({busy_o, bd_valid_o, key_valid_o}), 64'(0));

    build(3'b001, 1'b1, 1'b0, 7'd3, 7'd9, 8'd0);
    run_msg(1'b1, 1'b0, 2, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
